// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module     : program_loader
// Description: Boot-time loader sitting directly upstream of the cpu. Takes a
//              program image as a byte stream (big-endian 16-bit word count N
//              followed by N big-endian 16-bit words), writes each word into
//              the cpu word memory and holds the cpu in reset until the whole
//              image has been committed.
// Ports      : clk, rst            - clock, asynchronous active-high reset
//              in_valid/in_data    - byte stream input
//              in_ready            - loader accepts a byte this cycle
//              mem_we/mem_addr/
//              mem_wdata           - one-cycle word write strobe to cpu memory
//              cpu_rst             - cpu reset, high until load completes
//              done / error        - image loaded / header count too large
//              words_loaded        - number of words written so far
// Revision   : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int MEMORY_SIZE = 32,
    parameter int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    // One-cycle gap after the final write so the write strobe has completed
    // before the cpu is released.
    localparam logic [2:0] S_FLUSH   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    logic [2:0]            state_q,        state_d;
    logic [15:0]           count_q,        count_d;
    logic [7:0]            byte_q,         byte_d;
    logic                  mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
    logic [15:0]           mem_wdata_q,    mem_wdata_d;
    logic                  cpu_rst_q,      cpu_rst_d;
    logic                  done_q,         done_d;
    logic                  error_q,        error_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;

    logic                  w_ready;
    logic                  w_accept;
    logic [15:0]           w_len;
    logic [15:0]           w_next_words;

    assign w_ready      = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign w_accept     = in_valid && w_ready;
    assign w_len        = {byte_q, in_data};
    assign w_next_words = 16'(words_loaded_q) + 16'd1;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_d         = byte_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_LEN_HI: begin
                if (w_accept) begin
                    byte_d  = in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    count_d = w_len;
                    if (w_len == 16'd0) begin
                        state_d = S_DONE;
                    end else if (w_len > 16'(MEMORY_SIZE)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (w_accept) begin
                    byte_d  = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (w_accept) begin
                    mem_we_d       = 1'b1;
                    mem_wdata_d    = w_len;
                    mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
                    words_loaded_d = words_loaded_q + (ADDR_WIDTH+1)'(1);
                    state_d        = (w_next_words == count_q) ? S_FLUSH : S_DATA_HI;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                // DONE and ERROR are terminal; only rst leaves them.
                state_d = state_q;
            end
        endcase
    end

    // Status outputs are registered from the current state, which places the
    // release of cpu_rst one edge after the FSM reaches DONE.
    always_comb begin
        done_d    = (state_q == S_DONE);
        error_d   = (state_q == S_ERROR);
        cpu_rst_d = (state_q != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LEN_HI;
            count_q        <= 16'd0;
            byte_q         <= 8'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 16'd0;
            cpu_rst_q      <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_q         <= byte_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_rst_q      <= cpu_rst_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign in_ready     = w_ready;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module     : tb_program_loader
// Description: Self-checking bench for program_loader. Expected memory writes
//              are queued as each word is sent and popped as write strobes
//              appear; status outputs are compared inline per scenario.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int MEMORY_SIZE = 32;
    localparam int ADDR_WIDTH  = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    int checks   = 0;
    int failures = 0;
    int writes_seen = 0;
    logic [20:0] exp_q[$];

    program_loader #(
        .MEMORY_SIZE(MEMORY_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Advance one clock and compare any write strobe against the scoreboard.
    task automatic cycle();
        logic [20:0] e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, e[20:16], e[15:0]);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) cycle();
        in_valid = 1'b1;
        in_data  = b;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL byte_accept: in_ready=%b, required 1 for byte %h", in_ready, b);
            in_valid = 1'b0;
        end else begin
            cycle();
        end
    endtask

    task automatic send_word(input logic [4:0] addr, input logic [15:0] data, input int gap);
        exp_q.push_back({addr, data});
        send_byte(data[15:8], gap);
        send_byte(data[7:0], gap);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        cycle();
        cycle();
        rst      = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_rst, done, error, words_loaded, in_ready} !==
            {1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: we=%b addr=%0d wd=%h cpu_rst=%b done=%b err=%b wl=%0d rdy=%b, required 0 0 0000 1 0 0 0 1",
                     mem_we, mem_addr, mem_wdata, cpu_rst, done, error, words_loaded, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(5'd0, 16'h1234, 0);
        send_word(5'd1, 16'h5678, 0);
        send_word(5'd2, 16'h9ABC, 0);
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL b2b_release_k: done=%b cpu_rst=%b, required 0 1", done, cpu_rst);
        end
        cycle();
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release_k1: done=%b cpu_rst=%b we=%b, required 0 1 0", done, cpu_rst, mem_we);
        end
        cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 6'd3) begin
            failures++;
            $display("FAIL b2b_release_k2: done=%b cpu_rst=%b wl=%0d, required 1 0 3", done, cpu_rst, words_loaded);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing_writes: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_length();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_edge: in_ready=%b done=%b, required 0 0", in_ready, done);
        end
        cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || writes_seen != w0) begin
            failures++;
            $display("FAIL zero_len_done: done=%b cpu_rst=%b rdy=%b writes=%0d, required 1 0 0 0",
                     done, cpu_rst, in_ready, writes_seen - w0);
        end
    endtask

    task automatic test_oversize();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
            writes_seen != w0 || words_loaded !== 6'd0) begin
            failures++;
            $display("FAIL oversize: err=%b cpu_rst=%b rdy=%b done=%b writes=%0d wl=%0d, required 1 1 0 0 0 0",
                     error, cpu_rst, in_ready, done, writes_seen - w0, words_loaded);
        end
    endtask

    task automatic test_full_with_gaps();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_byte(8'h00, $urandom_range(0, 3));
        send_byte(8'h20, $urandom_range(0, 3));
        for (int i = 0; i < MEMORY_SIZE; i++) begin
            send_word(i[4:0], 16'($urandom), $urandom_range(0, 3));
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 6'd32 ||
            writes_seen - w0 != 32 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_gaps: done=%b cpu_rst=%b wl=%0d writes=%0d pending=%0d, required 1 0 32 32 0",
                     done, cpu_rst, words_loaded, writes_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        // Word 0 of the aborted image is still written before the reset.
        send_word(5'd0, 16'h1111, 0);
        send_byte(8'h22, 0);
        in_valid = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || words_loaded !== 6'd1) begin
            failures++;
            $display("FAIL midload_before: cpu_rst=%b done=%b wl=%0d, required 1 0 1", cpu_rst, done, words_loaded);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cpu_rst !== 1'b1 || words_loaded !== 6'd0 || mem_we !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midload_async_rst: cpu_rst=%b wl=%0d we=%b rdy=%b, required 1 0 0 1",
                     cpu_rst, words_loaded, mem_we, in_ready);
        end
        cycle();
        rst = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(5'd0, 16'hA5A5, 1);
        send_word(5'd1, 16'h5A5A, 0);
        in_valid = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL midload_cpu_rst: cpu_rst=%b, required 1", cpu_rst);
        end
        cycle();
        cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 6'd2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midload_done: done=%b cpu_rst=%b wl=%0d pending=%0d, required 1 0 2 0",
                     done, cpu_rst, words_loaded, exp_q.size());
        end
    endtask

    // Continues from the completed image of the previous scenario.
    task automatic test_after_done();
        int w0;
        w0 = writes_seen;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL after_done_ready: in_ready=%b, required 0", in_ready);
            end
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || mem_addr !== 5'd1 || mem_wdata !== 16'h5A5A ||
            words_loaded !== 6'd2 || writes_seen != w0) begin
            failures++;
            $display("FAIL after_done_hold: done=%b cpu_rst=%b addr=%0d wd=%h wl=%0d writes=%0d, required 1 0 1 5a5a 2 0",
                     done, cpu_rst, mem_addr, mem_wdata, words_loaded, writes_seen - w0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_back_to_back();
        test_zero_length();
        test_oversize();
        test_full_with_gaps();
        test_reset_mid_load();
        test_after_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
